// File: rtl/row_access_pkg.sv
// row_access_pkg: state encoding and default phase lengths for row_access_seq
package row_access_pkg;

    typedef enum logic [2:0] {IDLE, PRECH, WL, SENSE, DONE} state_t;

    localparam int PRE_CYC_DEF   = 1;
    localparam int WL_CYC_DEF    = 2;
    localparam int SENSE_CYC_DEF = 1;

endpackage

// File: rtl/row_access_seq.sv
// row_access_seq: Moore sequencer for one row access (precharge, word line, optional sense, done)
//   clk, rst_n            clock, async active-low reset
//   req, we, addr         request, write flag, row address (accepted only while ready)
//   ready                 idle, request may be accepted
//   pre_hi, pre_lo        latched address fields feeding the two 2-to-4 predecoders
//   precharge, wl_en,
//   write_en, sense_en    phase enables decoded from registered state
//   done                  one-cycle completion pulse
module row_access_seq
    import row_access_pkg::*;
#(
    parameter int PRE_CYC   = PRE_CYC_DEF,
    parameter int WL_CYC    = WL_CYC_DEF,
    parameter int SENSE_CYC = SENSE_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       we,
    input  logic [3:0] addr,
    output logic       ready,
    output logic [1:0] pre_hi,
    output logic [1:0] pre_lo,
    output logic       precharge,
    output logic       wl_en,
    output logic       write_en,
    output logic       sense_en,
    output logic       done
);

    localparam int MAXC = (PRE_CYC > WL_CYC) ? ((PRE_CYC > SENSE_CYC) ? PRE_CYC : SENSE_CYC)
                                              : ((WL_CYC > SENSE_CYC) ? WL_CYC : SENSE_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    state_t          state, nxt;
    logic [CW-1:0]   cnt, cnt_nxt, reload;
    logic            we_q;
    logic            last;

    assign last = (cnt == '0);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = req ? PRECH : IDLE;
            PRECH:   nxt = last ? WL : PRECH;
            WL:      nxt = last ? (we_q ? DONE : SENSE) : WL;
            SENSE:   nxt = last ? DONE : SENSE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // The shared counter holds (remaining cycles - 1) of the current phase;
    // every transition enters a different state, so a state change is a phase entry.
    always_comb begin
        reload  = (nxt == PRECH) ? CW'(PRE_CYC - 1) :
                  (nxt == WL)    ? CW'(WL_CYC - 1) :
                  (nxt == SENSE) ? CW'(SENSE_CYC - 1) : '0;
        cnt_nxt = (nxt != state) ? reload : (last ? cnt : cnt - CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            we_q   <= 1'b0;
            pre_hi <= 2'b00;
            pre_lo <= 2'b00;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                we_q   <= we;
                pre_hi <= addr[3:2];
                pre_lo <= addr[1:0];
            end
        end
    end

    assign ready     = (state == IDLE);
    assign precharge = (state == PRECH);
    assign wl_en     = (state == WL);
    assign write_en  = (state == WL) && we_q;
    assign sense_en  = (state == SENSE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_row_access_seq.sv
// tb_row_access_seq: randomized and directed bench for row_access_seq, default and 3/1/2 parameterisations
module tb_row_access_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [3:0] addr = 4'h0;

    logic       ready0, precharge0, wl_en0, write_en0, sense_en0, done0;
    logic [1:0] pre_hi0, pre_lo0;
    logic       ready1, precharge1, wl_en1, write_en1, sense_en1, done1;
    logic [1:0] pre_hi1, pre_lo1;

    int checks = 0;
    int failures = 0;

    int         e [2];
    logic [3:0] la [2];
    logic       lwe [2];
    int         pl [2] = '{1, 3};
    int         wlen [2] = '{2, 1};
    int         sl [2] = '{1, 2};

    always #5 clk = ~clk;

    row_access_seq dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .ready(ready0), .pre_hi(pre_hi0), .pre_lo(pre_lo0), .precharge(precharge0),
        .wl_en(wl_en0), .write_en(write_en0), .sense_en(sense_en0), .done(done0)
    );

    row_access_seq #(.PRE_CYC(3), .WL_CYC(1), .SENSE_CYC(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .ready(ready1), .pre_hi(pre_hi1), .pre_lo(pre_lo1), .precharge(precharge1),
        .wl_en(wl_en1), .write_en(write_en1), .sense_en(sense_en1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs from elapsed cycles since acceptance: {ready, addr, precharge, wl_en, write_en, sense_en, done}
    function automatic logic [9:0] expv(input int k);
        int t = e[k];
        logic [9:0] v = {1'b0, la[k], 5'b0};
        if (t == 0) v[9] = 1'b1;
        else if (t <= pl[k]) v[4] = 1'b1;
        else if (t <= pl[k] + wlen[k]) begin
            v[3] = 1'b1;
            v[2] = lwe[k];
        end else if (!lwe[k] && t <= pl[k] + wlen[k] + sl[k]) v[1] = 1'b1;
        else v[0] = 1'b1;
        return v;
    endfunction

    function automatic logic [9:0] got0();
        return {ready0, pre_hi0, pre_lo0, precharge0, wl_en0, write_en0, sense_en0, done0};
    endfunction

    function automatic logic [9:0] got1();
        return {ready1, pre_hi1, pre_lo1, precharge1, wl_en1, write_en1, sense_en1, done1};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e[k] = 0;
            la[k] = 4'h0;
            lwe[k] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int len = pl[k] + wlen[k] + (lwe[k] ? 0 : sl[k]) + 1;
            if (e[k] == 0) begin
                if (req) begin
                    e[k] = 1;
                    la[k] = addr;
                    lwe[k] = we;
                end
            end else if (e[k] < len) e[k]++;
            else e[k] = 0;
        end
        #1;
        check("cyc_dut0", 32'(got0()), 32'(expv(0)));
        check("cyc_dut1", 32'(got1()), 32'(expv(1)));
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must clear before any edge.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_dut0", 32'(got0()), 32'h200);
        check("rst_dut1", 32'(got1()), 32'h200);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        req = 1'b0;
        while (!(ready0 && ready1) && n < 20) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(ready0 && ready1), 32'd1);
    endtask

    task automatic access(input logic w, input logic [3:0] a, output int lat0, output int lat1);
        req = 1'b1;
        we = w;
        addr = a;
        tick();
        req = 1'b0;
        we = 1'($urandom);
        addr = 4'($urandom);
        lat0 = -1;
        lat1 = -1;
        for (int n = 1; n <= 20; n++) begin
            if (done0 && lat0 < 0) lat0 = n;
            if (done1 && lat1 < 0) lat1 = n;
            if (ready0 && ready1) break;
            tick();
        end
    endtask

    initial begin
        int l0, l1, nd, last_d;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check("reset_dut0", 32'(got0()), 32'h200);
        check("reset_dut1", 32'(got1()), 32'h200);
        #1 rst_n = 1'b1;
        tick();

        access(1'b0, 4'b1001, l0, l1);
        check("read_lat_dut0", 32'(l0), 32'd5);
        check("read_lat_dut1", 32'(l1), 32'd7);
        check("read_pre", 32'({pre_hi0, pre_lo0}), 32'b1001);

        access(1'b1, 4'b0110, l0, l1);
        check("write_lat_dut0", 32'(l0), 32'd4);
        check("write_lat_dut1", 32'(l1), 32'd5);
        check("write_pre", 32'({pre_hi0, pre_lo0}), 32'b0110);

        req = 1'b1; we = 1'b0; addr = 4'b1001;
        tick();
        req = 1'b0;
        tick();
        req = 1'b1; addr = 4'b1111;
        nd = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (n == 1) req = 1'b0;
            if (done0) nd++;
        end
        check("busy_done_count", 32'(nd), 32'd1);
        check("busy_pre", 32'({pre_hi0, pre_lo0}), 32'b1001);
        wait_idle();

        req = 1'b1; we = 1'b0; addr = 4'b0011;
        tick();
        req = 1'b0;
        tick();
        mid_reset();
        nd = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (done0 || done1) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        access(1'b0, 4'b1100, l0, l1);
        check("post_rst_lat", 32'(l0), 32'd5);

        req = 1'b1; we = 1'b0; addr = 4'b0101;
        last_d = -1;
        for (int n = 1; n <= 26; n++) begin
            tick();
            if (done0) begin
                if (last_d >= 0) check("b2b_spacing", 32'(n - last_d), 32'd6);
                last_d = n;
            end
        end
        wait_idle();

        for (int n = 0; n < 400; n++) begin
            req = ($urandom_range(0, 2) == 0);
            we = 1'($urandom);
            addr = 4'($urandom);
            tick();
            if ($urandom_range(0, 49) == 0) mid_reset();
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/row_access_seq.md
ROW_ACCESS_SEQ -- requirements
Module: row_access_seq

Interface
REQ-001 Parameters SHALL be: PRE_CYC, 1, precharge phase length in cycles (>=1).
REQ-002 Parameters SHALL be: WL_CYC, 2, word-line phase length in cycles (>=1).
REQ-003 Parameters SHALL be: SENSE_CYC, 1, sense phase length in cycles (>=1, reads only).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req  input  1  access request, sampled when ready=1.
REQ-008 we  input  1  1=write, 0=read, sampled with req.
REQ-009 addr  input  4  row address; [3:2] upper field, [1:0] lower field.
REQ-010 ready  output  1  high only in IDLE; request may be accepted.
REQ-011 pre_hi  output  2  latched addr[3:2], driven to the upper 2-to-4 predecoder input.
REQ-012 pre_lo  output  2  latched addr[1:0], driven to the lower 2-to-4 predecoder input.
REQ-013 precharge  output  1  bit-line precharge enable.
REQ-014 wl_en  output  1  word-line enable gating the predecoder outputs.
REQ-015 write_en  output  1  write driver enable.
REQ-016 sense_en  output  1  sense amplifier enable.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 States SHALL be IDLE, PRECH, WL, SENSE, DONE, held in a registered state variable; all control outputs SHALL be decoded from registered state only (Moore).
REQ-019 Acceptance SHALL occur on a rising edge with req=1 in IDLE; addr and we SHALL be latched on that edge and state SHALL go to PRECH.
REQ-020 PRECH SHALL last PRE_CYC cycles with precharge=1, then go to WL.
REQ-021 WL SHALL last WL_CYC cycles with wl_en=1, and write_en=1 if the latched we=1.
REQ-022 After WL, a read SHALL go to SENSE (SENSE_CYC cycles, sense_en=1, wl_en=0); a write SHALL skip SENSE and go to DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 With defaults, done SHALL be high in the 5th cycle after acceptance for a read and the 4th for a write; ready SHALL reassert one cycle after done.
REQ-025 precharge, wl_en, sense_en and write_en SHALL be mutually exclusive except write_en, which SHALL coincide only with wl_en.
REQ-026 pre_hi/pre_lo SHALL change only on an accepting edge and SHALL hold stable from PRECH through DONE and through subsequent IDLE cycles.
REQ-027 req while ready=0 SHALL be ignored (no queueing); addr/we changes while busy SHALL not affect outputs.
REQ-028 A single phase-length down-counter SHALL be shared by all phases, sized for the largest parameter, reloaded on each state entry.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, ready=1, pre_hi=0, pre_lo=0, precharge=0, wl_en=0, write_en=0, sense_en=0, done=0, counter=0, latched we=0.
REQ-030 Reset asserted mid-access SHALL abort the access with no done pulse; the first edge after release with req=1 SHALL be accepted.

Structure
REQ-031 State encoding and default phase-length constants SHALL live in a shared package row_access_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; its pre_hi/pre_lo outputs connect directly to two PreDecoder_2_4 instances in the row-decode path.

Verification
REQ-033 Read: req=1, we=0, addr=4'b1001 -> pre_hi=10, pre_lo=01; precharge 1 cycle, wl_en 2 cycles, sense_en 1 cycle, done in cycle 5, write_en never high.
REQ-034 Write: req=1, we=1, addr=4'b0110 -> precharge 1, wl_en+write_en 2 cycles, sense_en never high, done in cycle 4.
REQ-035 Busy request: second req with addr=4'b1111 during WL -> ignored; pre_hi/pre_lo stay at the first address; exactly one done.
REQ-036 Reset mid-access: rst_n=0 during WL -> all outputs 0 immediately except ready=1; no done; next read completes normally.
REQ-037 Back-to-back: req held high continuously -> accepts every 6 cycles (read), done pulses spaced 6 cycles apart.
REQ-038 Parameterised: PRE_CYC=3, WL_CYC=1, SENSE_CYC=2 read -> phases 3/1/2 cycles, done in cycle 7.
